rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive cycles a pending side requester may be blocked by writeback before it is force-granted.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width.
REQ-003 SHALL have parameter DATA_W, default 32: register data width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wb_wr / wb_addr / wb_data  in  1/ADDR_W/DATA_W  pipeline writeback request; no ready signal, held by the pipeline while wb_stall=1.
REQ-007 wb_stall  out  1  combinational; high in any cycle where a writeback request is present but not taken.
REQ-008 exc_valid / exc_addr / exc_data  in  1/ADDR_W/DATA_W  exception-unit request ($26/$27 EPC/cause writes).
REQ-009 exc_ready  out  1  combinational; the exception request is taken in a cycle where exc_valid & exc_ready.
REQ-010 uart_valid / uart_addr / uart_data  in  1/ADDR_W/DATA_W  UART-status requester.
REQ-011 uart_ready  out  1  combinational; same handshake rule as exc_ready.
REQ-012 rf_wr / rf_addr / rf_data  out  1/ADDR_W/DATA_W  registered write port to the register file.
REQ-013 starve_cnt  out  4  debug; current starvation counter.

Function
REQ-014 SHALL grant at most one requester per cycle; the granted write appears on rf_* exactly 1 cycle later for 1 cycle.
REQ-015 In state NORMAL, wb_wr=1 SHALL always win; exc_ready=uart_ready=0 and wb_stall=0.
REQ-016 With wb_wr=0 in NORMAL, side requesters SHALL be granted round-robin; rr pointer resets to exc and flips only on a side grant.
REQ-017 starve_cnt SHALL increment each cycle with (exc_valid|uart_valid) & wb_wr & state==NORMAL, clear on any side grant, and saturate at STARVE_LIMIT.
REQ-018 When starve_cnt==STARVE_LIMIT-1 and incrementing, the next state SHALL be FORCE.
REQ-019 In FORCE (exactly one cycle): grant the rr-selected valid side requester (else the other), wb_stall=wb_wr, writeback not taken, then return to NORMAL with starve_cnt=0.
REQ-020 If both side valids drop before FORCE, FORCE SHALL grant nothing, keep wb_stall=0, and return to NORMAL.
REQ-021 A grant to address 0 SHALL complete its handshake but SHALL produce rf_wr=0.
REQ-022 rf_addr/rf_data SHALL hold their last values when rf_wr=0.
REQ-023 ready outputs SHALL NOT depend on their own valid (no combinational loop).
REQ-024 Same-address writes in consecutive cycles SHALL be issued in grant order; the later write overwrites.

Reset
REQ-025 reset=1 at posedge clk SHALL force: state=NORMAL, rr=exc, starve_cnt=0, rf_wr=0, rf_addr=0, rf_data=0.
REQ-026 While reset=1, exc_ready=uart_ready=0 and wb_stall=0; a write granted in the reset cycle is discarded.
REQ-027 Reset asserted during FORCE SHALL abandon the forced grant; no write is issued.

Structure
REQ-028 State encoding (NORMAL, FORCE), requester index enum and STARVE_LIMIT default SHALL live in shared package rf_arb_pkg.
REQ-029 One sub-module SHALL be natural: rf_rr_pick (2-way round-robin pick from valids + pointer); all else flat.

Verification
REQ-030 wb_wr=1 addr 5 data 0xA5 alone -> next cycle rf_wr=1, rf_addr=5, rf_data=0xA5; wb_stall=0.
REQ-031 exc_valid and uart_valid held, wb_wr=0 -> grants alternate exc, uart, exc; first rf write is exc_data.
REQ-032 wb_wr=1 continuously, exc_valid=1 held (addr 26, 0x80000180) -> wb_stall=1 in 9th cycle exactly, exc write on rf_* in 10th, wb resumes in 10th cycle.
REQ-033 uart_valid addr 0 data 0x1 -> uart_ready=1, rf_wr stays 0.
REQ-034 reset pulsed in FORCE cycle -> no rf_wr, starve_cnt=0, exc_valid still pending and granted once wb_wr=0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared state encoding, requester index and defaults for the RF write arbiter
package rf_arb_pkg;
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;
    localparam int STARVE_LIMIT_DEF = 8;
    typedef enum logic {
        REQ_EXC  = 1'b0,
        REQ_UART = 1'b1
    } req_idx_e;
endpackage

// File: rtl/rf_rr_pick.sv
// rf_rr_pick: 2-way round-robin select; a side is selectable when it holds priority or the other side is idle
module rf_rr_pick
    import rf_arb_pkg::*;
(
    input  logic valid_exc,
    input  logic valid_uart,
    input  logic ptr,
    output logic sel_exc,
    output logic sel_uart
);
    // each select looks only at the other side's valid so ready never loops back on its own valid
    always_comb begin
        sel_exc  = (ptr == REQ_EXC) | ~valid_uart;
        sel_uart = (ptr == REQ_UART) | ~valid_exc;
    end
endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: single-port register-file write arbiter, writeback first with starvation-forced side grants
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_wr,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_addr,
    input  logic [DATA_W-1:0] exc_data,
    output logic              exc_ready,
    input  logic              uart_valid,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_data,
    output logic              uart_ready,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic [3:0]        starve_cnt
);
    logic [0:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic [3:0]        starve_q, starve_d;
    logic              rf_wr_q, rf_wr_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              sel_exc, sel_uart;
    logic              side_ok, force_side, wb_take, gnt_exc, gnt_uart, side_gnt, starve_inc;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    rf_rr_pick u_pick (
        .valid_exc (exc_valid),
        .valid_uart(uart_valid),
        .ptr       (rr_q),
        .sel_exc   (sel_exc),
        .sel_uart  (sel_uart)
    );

    // grant selection, handshakes and next-state computation
    always_comb begin
        side_ok    = ~reset & ((state_q == ST_NORMAL & ~wb_wr) | state_q == ST_FORCE);
        exc_ready  = side_ok & sel_exc;
        uart_ready = side_ok & sel_uart;
        force_side = state_q == ST_FORCE & (exc_valid | uart_valid);
        wb_stall   = ~reset & wb_wr & force_side;
        wb_take    = ~reset & wb_wr & ~force_side;
        gnt_exc    = exc_valid & exc_ready;
        gnt_uart   = uart_valid & uart_ready;
        side_gnt   = gnt_exc | gnt_uart;
        g_addr     = wb_take ? wb_addr : gnt_exc ? exc_addr : uart_addr;
        g_data     = wb_take ? wb_data : gnt_exc ? exc_data : uart_data;
        rf_wr_d    = (wb_take | side_gnt) & (g_addr != '0);
        rf_addr_d  = rf_wr_d ? g_addr : rf_addr_q;
        rf_data_d  = rf_wr_d ? g_data : rf_data_q;
        starve_inc = state_q == ST_NORMAL & wb_wr & (exc_valid | uart_valid);
        starve_d   = (side_gnt | state_q == ST_FORCE) ? 4'd0 :
                     starve_inc ? (starve_q == 4'(STARVE_LIMIT) ? starve_q : starve_q + 4'd1) : starve_q;
        state_d    = (starve_inc & starve_q == 4'(STARVE_LIMIT - 1)) ? ST_FORCE : ST_NORMAL;
        rr_d       = side_gnt ? ~rr_q : rr_q;
    end

    // state and registered write port; reset discards any grant made in the reset cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_NORMAL;
            rr_q      <= REQ_EXC;
            starve_q  <= 4'd0;
            rf_wr_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            starve_q  <= starve_d;
            rf_wr_q   <= rf_wr_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_wr      = rf_wr_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;
    assign starve_cnt = starve_q;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: scenario tasks with a write scoreboard checked on the falling edge
module tb_rf_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wr, exc_valid, uart_valid;
    logic [4:0]  wb_addr, exc_addr, uart_addr;
    logic [31:0] wb_data, exc_data, uart_data;
    logic        wb_stall, exc_ready, uart_ready, rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [3:0]  starve_cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t q[$];

    rf_wr_arbiter dut (
        .clk(clk), .reset(reset),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
        .exc_valid(exc_valid), .exc_addr(exc_addr), .exc_data(exc_data), .exc_ready(exc_ready),
        .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_data(uart_data), .uart_ready(uart_ready),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rf_wr === 1'b1) begin
            checks++;
            if (q.size() == 0 || q[0].due != cyc) begin
                errors++;
                $display("FAIL unexpected_write cyc %0d got addr %0d data %0h want no write", cyc, rf_addr, rf_data);
            end else begin
                if (rf_addr !== q[0].a || rf_data !== q[0].d) begin
                    errors++;
                    $display("FAIL write_value cyc %0d got %0d/%0h want %0d/%0h", cyc, rf_addr, rf_data, q[0].a, q[0].d);
                end
                void'(q.pop_front());
            end
        end
        if (q.size() > 0 && q[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write cyc %0d got rf_wr %b want addr %0d data %0h", cyc, rf_wr, q[0].a, q[0].d);
            void'(q.pop_front());
        end
    end

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        q.push_back('{cyc + 1, a, d});
    endtask

    task automatic idle_inputs();
        wb_wr = 0; exc_valid = 0; uart_valid = 0;
        wb_addr = 0; exc_addr = 0; uart_addr = 0;
        wb_data = 0; exc_data = 0; uart_data = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic drain(input string name);
        idle_inputs();
        tick(); tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending want 0", name, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        wb_wr = 1; wb_addr = 4; wb_data = 32'h44;
        exc_valid = 1; exc_addr = 6; uart_valid = 1; uart_addr = 7;
        tick();
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", wb_stall); end
        checks++; if (exc_ready !== 1'b0) begin errors++; $display("FAIL reset_exc_ready got %b want 0", exc_ready); end
        checks++; if (uart_ready !== 1'b0) begin errors++; $display("FAIL reset_uart_ready got %b want 0", uart_ready); end
        tick();
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL reset_rf_wr got %b want 0", rf_wr); end
        checks++; if (rf_addr !== 5'd0 || rf_data !== 32'd0) begin errors++; $display("FAIL reset_rf got %0d/%0h want 0/0", rf_addr, rf_data); end
        checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve got %0d want 0", starve_cnt); end
        reset = 0;
        drain("reset");
    endtask

    task automatic test_wb();
        do_reset();
        wb_wr = 1; wb_addr = 5; wb_data = 32'hA5;
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL wb_stall got %b want 0", wb_stall); end
        push(5, 32'hA5);
        tick();
        drain("wb");
    endtask

    task automatic test_rr();
        do_reset();
        exc_valid = 1; exc_addr = 26; exc_data = 32'hE0;
        uart_valid = 1; uart_addr = 12; uart_data = 32'hD0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (exc_ready !== (i % 2 == 0) || uart_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_ready_%0d got %b%b want %b%b", i, exc_ready, uart_ready, i % 2 == 0, i % 2 == 1);
            end
            if (i % 2 == 0) push(26, 32'hE0); else push(12, 32'hD0);
            tick();
        end
        drain("rr");
    endtask

    task automatic test_starve();
        do_reset();
        exc_valid = 1; exc_addr = 26; exc_data = 32'h80000180;
        wb_wr = 1;
        for (int i = 1; i <= 10; i++) begin
            wb_addr = 5'(i < 10 ? i : 9);
            wb_data = 32'h100 + (i < 10 ? i : 9);
            #1;
            checks++;
            if (starve_cnt !== 4'(i == 10 ? 0 : i - 1)) begin
                errors++;
                $display("FAIL starve_cnt_%0d got %0d want %0d", i, starve_cnt, i == 10 ? 0 : i - 1);
            end
            checks++;
            if (wb_stall !== (i == 9) || exc_ready !== (i == 9)) begin
                errors++;
                $display("FAIL starve_grant_%0d got stall %b exc_ready %b want %b", i, wb_stall, exc_ready, i == 9);
            end
            if (i == 9) push(26, 32'h80000180); else push(wb_addr, wb_data);
            tick();
            if (i == 9) exc_valid = 0;
        end
        drain("starve");
    endtask

    task automatic test_zero();
        do_reset();
        wb_wr = 1; wb_addr = 7; wb_data = 32'h77;
        push(7, 32'h77);
        tick();
        wb_wr = 0;
        uart_valid = 1; uart_addr = 0; uart_data = 32'h1;
        #1;
        checks++; if (uart_ready !== 1'b1) begin errors++; $display("FAIL zero_uart_ready got %b want 1", uart_ready); end
        tick();
        uart_valid = 0;
        #1;
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL zero_rf_wr got %b want 0", rf_wr); end
        checks++; if (rf_addr !== 5'd7 || rf_data !== 32'h77) begin errors++; $display("FAIL zero_hold got %0d/%0h want 7/77", rf_addr, rf_data); end
        drain("zero");
    endtask

    task automatic test_force_reset();
        do_reset();
        exc_valid = 1; exc_addr = 26; exc_data = 32'hCAFE;
        wb_wr = 1;
        for (int i = 1; i <= 8; i++) begin
            wb_addr = 5'(i); wb_data = 32'h200 + i;
            push(wb_addr, wb_data);
            tick();
        end
        reset = 1;
        #1;
        checks++; if (exc_ready !== 1'b0 || wb_stall !== 1'b0) begin errors++; $display("FAIL force_reset_hs got %b%b want 00", exc_ready, wb_stall); end
        tick();
        reset = 0; wb_wr = 0;
        #1;
        checks++; if (rf_wr !== 1'b0) begin errors++; $display("FAIL force_reset_rf_wr got %b want 0", rf_wr); end
        checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL force_reset_starve got %0d want 0", starve_cnt); end
        checks++; if (exc_ready !== 1'b1) begin errors++; $display("FAIL force_reset_exc_ready got %b want 1", exc_ready); end
        push(26, 32'hCAFE);
        tick();
        drain("force_reset");
    endtask

    task automatic test_force_drop();
        do_reset();
        uart_valid = 1; uart_addr = 27; uart_data = 32'hBEEF;
        wb_wr = 1;
        for (int i = 1; i <= 10; i++) begin
            wb_addr = 5'(i); wb_data = 32'h300 + i;
            if (i == 9) uart_valid = 0;
            #1;
            if (i == 9) begin
                checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL drop_stall got %b want 0", wb_stall); end
            end
            if (i == 10) begin
                checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL drop_starve got %0d want 0", starve_cnt); end
                uart_valid = 1;
                #1;
                checks++; if (uart_ready !== 1'b0 || wb_stall !== 1'b0) begin errors++; $display("FAIL drop_normal got %b%b want 00", uart_ready, wb_stall); end
            end
            push(wb_addr, wb_data);
            tick();
        end
        drain("force_drop");
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_wr = 1; wb_addr = 3; wb_data = 32'h1;
        push(3, 32'h1);
        tick();
        wb_wr = 0;
        exc_valid = 1; exc_addr = 3; exc_data = 32'h2;
        push(3, 32'h2);
        tick();
        exc_valid = 0;
        tick();
        checks++; if (rf_data !== 32'h2) begin errors++; $display("FAIL b2b_last got %0h want 2", rf_data); end
        drain("b2b");
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_wb();
        test_rr();
        test_starve();
        test_zero();
        test_force_reset();
        test_force_drop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
